// File: rtl/cic_interp_var.sv
// Variable 2**n CIC interpolator: combs at the input rate, zero-stuff, integrators per out_tick,
// with per-R gain normalisation so DC in gives DC out at the same amplitude.
module cic_interp_var #(
  parameter int unsigned STAGES    = 3,
  parameter int unsigned MAX_LOG2  = 11,
  parameter int unsigned IN_WIDTH  = 18,
  parameter int unsigned OUT_WIDTH = 18,
  parameter int unsigned MD        = 18
) (
  input  logic                 clock_i,
  input  logic                 reset_ni,
  input  logic [MD-1:0]        interpolation_i,
  input  logic                 out_tick_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [IN_WIDTH-1:0]  in_data_i,
  output logic                 out_strobe_o,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic                 underrun_o
);

  localparam int unsigned GROWTH = STAGES * MAX_LOG2;
  localparam int unsigned CW     = IN_WIDTH + STAGES;
  localparam int unsigned IW     = IN_WIDTH + GROWTH;
  localparam int unsigned LW     = $clog2(MAX_LOG2 + 1);

  logic                  buf_full_q, buf_full_d;
  logic [IN_WIDTH-1:0]   buf_data_q, buf_data_d;
  logic [MAX_LOG2-1:0]   phase_q, phase_d;
  logic [LW-1:0]         r_log_q, r_log_d;
  logic signed [CW-1:0]  dly_q [STAGES];
  logic signed [CW-1:0]  dly_d [STAGES];
  logic signed [IW-1:0]  integ_q [STAGES];
  logic signed [IW-1:0]  integ_d [STAGES];
  logic [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                  out_strobe_q, out_strobe_d;
  logic                  underrun_q, underrun_d;

  logic                  req_legal;
  logic [LW-1:0]         req_log;
  logic [LW-1:0]         log_act;
  logic                  consume, clr, handshake;
  logic [MAX_LOG2-1:0]   mask;
  logic [IN_WIDTH-1:0]   sample;
  logic signed [CW-1:0]  comb [STAGES+1];
  logic signed [IW-1:0]  integ_last, shifted;
  int unsigned           shift_amt;

  assign in_ready_o   = ~buf_full_q;
  assign out_strobe_o = out_strobe_q;
  assign out_data_o   = out_data_q;
  assign underrun_o   = underrun_q;

  always_comb begin
    req_legal = 1'b0;
    req_log   = '0;
    for (int i = 0; i <= int'(MAX_LOG2); i++) begin
      if (interpolation_i == (MD'(1) << i)) begin
        req_legal = 1'b1;
        req_log   = LW'(i);
      end
    end

    handshake = in_valid_i & ~buf_full_q;
    consume   = out_tick_i && (phase_q == '0);
    // A legal new R takes effect on a consume tick and restarts the filter from zero state.
    clr       = consume && req_legal && (req_log != r_log_q);
    log_act   = clr ? req_log : r_log_q;
    mask      = MAX_LOG2'((32'd1 << log_act) - 32'd1);
    sample    = buf_full_q ? buf_data_q : '0;

    // Combs run at a common width; stage k values never exceed IN_WIDTH+k bits.
    comb[0] = {{STAGES{sample[IN_WIDTH-1]}}, sample};
    for (int k = 0; k < int'(STAGES); k++) begin
      comb[k+1] = comb[k] - (clr ? CW'(0) : dly_q[k]);
    end

    buf_full_d   = buf_full_q;
    buf_data_d   = buf_data_q;
    phase_d      = phase_q;
    r_log_d      = r_log_q;
    out_data_d   = out_data_q;
    out_strobe_d = out_tick_i;
    underrun_d   = underrun_q | (consume & ~buf_full_q);
    integ_last   = clr ? IW'(0) : integ_q[STAGES-1];
    shift_amt    = (STAGES - 1) * int'(log_act);
    shifted      = integ_last >>> shift_amt;
    for (int k = 0; k < int'(STAGES); k++) begin
      dly_d[k]   = dly_q[k];
      integ_d[k] = integ_q[k];
    end

    if (consume) buf_full_d = 1'b0;
    if (handshake) begin
      buf_full_d = 1'b1;
      buf_data_d = in_data_i;
    end

    if (out_tick_i) begin
      phase_d    = clr ? (MAX_LOG2'(1) & mask) : ((phase_q + MAX_LOG2'(1)) & mask);
      integ_d[0] = (clr ? IW'(0) : integ_q[0])
                 + (consume ? {{(IW-CW){comb[STAGES][CW-1]}}, comb[STAGES]} : IW'(0));
      for (int k = 1; k < int'(STAGES); k++) begin
        integ_d[k] = clr ? IW'(0) : (integ_q[k] + integ_q[k-1]);
      end
      if (log_act == '0) out_data_d = sample[IN_WIDTH-1 -: OUT_WIDTH];
      else               out_data_d = shifted[IN_WIDTH-1 -: OUT_WIDTH];
    end

    if (consume) begin
      r_log_d = log_act;
      for (int k = 0; k < int'(STAGES); k++) dly_d[k] = comb[k];
    end
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      buf_full_q   <= 1'b0;
      buf_data_q   <= '0;
      phase_q      <= '0;
      r_log_q      <= '0;
      out_data_q   <= '0;
      out_strobe_q <= 1'b0;
      underrun_q   <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        dly_q[k]   <= '0;
        integ_q[k] <= '0;
      end
    end else begin
      buf_full_q   <= buf_full_d;
      buf_data_q   <= buf_data_d;
      phase_q      <= phase_d;
      r_log_q      <= r_log_d;
      out_data_q   <= out_data_d;
      out_strobe_q <= out_strobe_d;
      underrun_q   <= underrun_d;
      for (int k = 0; k < int'(STAGES); k++) begin
        dly_q[k]   <= dly_d[k];
        integ_q[k] <= integ_d[k];
      end
    end
  end

endmodule

// File: tb/tb_cic_interp_var.sv
// Directed bench for cic_interp_var: DC settling, R=1 bypass, impulse response,
// underrun, R switching and asynchronous reset.
module tb_cic_interp_var;
  localparam int IW = 18;
  localparam int OW = 18;
  localparam int MD = 18;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [MD-1:0] interp = '0;
  logic          out_tick = 1'b0;
  logic          in_valid = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_ready, out_strobe, underrun;
  logic [OW-1:0] out_data;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  cic_interp_var #(
    .STAGES   (3),
    .MAX_LOG2 (11),
    .IN_WIDTH (IW),
    .OUT_WIDTH(OW),
    .MD       (MD)
  ) dut (
    .clock_i        (clock),
    .reset_ni       (reset_n),
    .interpolation_i(interp),
    .out_tick_i     (out_tick),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .out_strobe_o   (out_strobe),
    .out_data_o     (out_data),
    .underrun_o     (underrun)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [31:0] sdata();
    return 32'($signed(out_data));
  endfunction

  // One clock; inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic tick);
    out_tick = tick;
    @(posedge clock);
    #1;
    out_tick = 1'b0;
  endtask

  task automatic do_reset(input int r);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    out_tick = 1'b0;
    interp   = MD'(r);
    step(1'b0);
    step(1'b0);
    check("rst_data", sdata(), 0);
    check("rst_strobe", 32'(out_strobe), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_ready", 32'(in_ready), 1);
    reset_n = 1'b1;
    step(1'b0);
  endtask

  task automatic load(input int v);
    for (int i = 0; i < 8 && !in_ready; i++) step(1'b0);
    check("load_ready", 32'(in_ready), 1);
    in_data  = IW'(v);
    in_valid = 1'b1;
    step(1'b0);
    in_valid = 1'b0;
  endtask

  // R=8 DC run from reset: output must settle to exactly the input level.
  task automatic dc_test();
    do_reset(8);
    in_data  = IW'(1000);
    in_valid = 1'b1;
    step(1'b0);
    step(1'b0);
    for (int t = 0; t < 80; t++) begin
      step(1'b1);
      if (t >= 72) begin
        check("dc8_data", sdata(), 1000);
        check("dc8_strobe", 32'(out_strobe), 1);
      end
      step(1'b0);
      if (t == 79) check("dc8_strobe_low", 32'(out_strobe), 0);
      step(1'b0);
    end
    check("dc8_underrun", 32'(underrun), 0);
  endtask

  int imp_exp [16] = '{0, 0, 0, 16, 48, 96, 160, 192, 192, 160, 96, 48, 16, 0, 0, 0};

  initial begin
    // 1. DC at R=8
    dc_test();

    // 2. R=1 bypass with a ramp
    do_reset(1);
    for (int v = 0; v < 6; v++) begin
      load(v);
      step(1'b1);
      check("r1_data", sdata(), v);
      check("r1_strobe", 32'(out_strobe), 1);
      step(1'b0);
      check("r1_strobe_low", 32'(out_strobe), 0);
    end
    check("r1_underrun", 32'(underrun), 0);

    // 3. R=4 impulse response, 256 * boxcar^3 / 16
    do_reset(4);
    load(256);
    for (int t = 0; t < 16; t++) begin
      step(1'b1);
      check($sformatf("imp_t%0d", t), sdata(), imp_exp[t]);
      step(1'b0);
      step(1'b0);
    end

    // 4. R=16 underrun, then DC -500
    do_reset(16);
    step(1'b1);
    check("ur_flag", 32'(underrun), 1);
    check("ur_data", sdata(), 0);
    step(1'b0);
    for (int t = 0; t < 20; t++) begin
      step(1'b1);
      step(1'b0);
    end
    check("ur_zero", sdata(), 0);
    in_data  = IW'(-500);
    in_valid = 1'b1;
    for (int t = 0; t < 120; t++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
    check("ur_dc_data", sdata(), -500);
    check("ur_sticky", 32'(underrun), 1);

    // 5. R switch 8 -> 64 mid-stream, then illegal 3
    do_reset(8);
    in_data  = IW'(1000);
    in_valid = 1'b1;
    step(1'b0);
    step(1'b0);
    for (int t = 0; t < 81; t++) begin
      if (t == 78) interp = MD'(64);
      step(1'b1);
      if (t >= 72 && t < 80) check("sw8_data", sdata(), 1000);
      if (t == 80) check("sw_clear", sdata(), 0);
      step(1'b0);
      step(1'b0);
    end
    for (int t = 0; t < 400; t++) begin
      step(1'b1);
      if (t >= 396) check("sw64_data", sdata(), 1000);
      step(1'b0);
      step(1'b0);
    end
    interp = MD'(3);
    for (int t = 0; t < 150; t++) begin
      step(1'b1);
      check("sw_illegal", sdata(), 1000);
      step(1'b0);
      step(1'b0);
    end
    check("sw_underrun", 32'(underrun), 0);

    // 6. async reset mid-burst, right after a strobe
    do_reset(8);
    in_data  = IW'(1000);
    in_valid = 1'b1;
    for (int t = 0; t < 40; t++) begin
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
    step(1'b1);
    check("pre_rst_strobe", 32'(out_strobe), 1);
    reset_n = 1'b0;
    #1;
    check("async_data", sdata(), 0);
    check("async_strobe", 32'(out_strobe), 0);
    check("async_underrun", 32'(underrun), 0);
    check("async_ready", 32'(in_ready), 1);
    dc_test();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
